// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache/memory arbiter: FSM states, owner codes, default widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int MASK_W_DEF = 16;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational requester selector. Fixed dcache priority by default; round-robin
// between the two caches when ARB_ROUND_ROBIN_EN is defined. Grant is one-hot {d, i}.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       i_i_valid,
  input  logic       i_d_valid,
  input  logic       i_last_owner,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_i_valid && i_d_valid) o_grant = (i_last_owner == OWNER_I) ? 2'b10 : 2'b01;
`else
    if (i_i_valid && i_d_valid) o_grant = 2'b10;
`endif
    else if (i_d_valid)         o_grant = 2'b10;
    else if (i_i_valid)         o_grant = 2'b01;
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unused_last;
  assign w_unused_last = i_last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache and dcache, one transaction outstanding.
// Optional round-robin arbitration is enabled with ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MASK_W = MASK_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_rnw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [MASK_W-1:0] d_req_wmask,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rnw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              err_spurious,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a request transfers on a cycle where *_valid and *_ready are both 1;
  // ready is only offered in IDLE, and valid/payload must stay stable until then.
  arb_state_e        r_state, w_state_nxt;
  logic              r_owner;
  logic              r_rnw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_i_resp_data;
  logic [DATA_W-1:0] r_d_resp_data;
  logic              r_err;
  logic [1:0]        w_grant;
  logic              w_grant_en;
  logic              w_last_owner;

  arb_pick u_pick (
    .i_i_valid    (i_req_valid),
    .i_d_valid    (d_req_valid),
    .i_last_owner (w_last_owner),
    .o_grant      (w_grant)
  );

  assign w_grant_en = (r_state == ST_IDLE) && (|w_grant);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_owner;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_last_owner <= OWNER_I;
    else if (w_grant_en) r_last_owner <= w_grant[1] ? OWNER_D : OWNER_I;
  end
  assign w_last_owner = r_last_owner;
`else
  assign w_last_owner = OWNER_I;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (|w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   if (mem_req_ready) w_state_nxt = r_rnw ? ST_WAIT_RD : ST_RESP;
      ST_WAIT_RD: if (mem_resp_valid) w_state_nxt = ST_RESP;
      ST_RESP:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Payload latch; icache requests are always reads with no write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= OWNER_I;
      r_rnw   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_en) begin
      r_owner <= w_grant[1] ? OWNER_D : OWNER_I;
      r_rnw   <= w_grant[1] ? d_req_rnw : 1'b1;
      r_addr  <= w_grant[1] ? d_req_addr : i_req_addr;
      r_wdata <= w_grant[1] ? d_req_wdata : '0;
      r_wmask <= w_grant[1] ? d_req_wmask : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_resp_data <= '0;
      r_d_resp_data <= '0;
      r_err         <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_RD && mem_resp_valid) begin
        if (r_owner == OWNER_D) r_d_resp_data <= mem_resp_data;
        else                    r_i_resp_data <= mem_resp_data;
      end
      if (r_state == ST_ISSUE && mem_req_ready && !r_rnw) r_d_resp_data <= '0;
      if (r_state != ST_WAIT_RD && mem_resp_valid) r_err <= 1'b1;
    end
  end

  // Readies are gated by reset so every output reads 0 while reset is held.
  assign i_req_ready   = reset_n && w_grant_en && w_grant[0];
  assign d_req_ready   = reset_n && w_grant_en && w_grant[1];
  assign i_resp_valid  = (r_state == ST_RESP) && (r_owner == OWNER_I);
  assign d_resp_valid  = (r_state == ST_RESP) && (r_owner == OWNER_D);
  assign i_resp_data   = r_i_resp_data;
  assign d_resp_data   = r_d_resp_data;
  assign mem_req_valid = (r_state == ST_ISSUE);
  assign mem_req_rnw   = r_rnw;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wmask = r_wmask;
  assign busy          = (r_state != ST_IDLE);
  assign err_spurious  = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level model of arbitration, latency,
// routing and a byte-masked memory, plus directed reset/spurious-response scenarios.
module tb_mem_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_req_valid, i_req_ready;
  logic [27:0]  i_req_addr;
  logic         i_resp_valid;
  logic [127:0] i_resp_data;
  logic         d_req_valid, d_req_ready, d_req_rnw;
  logic [27:0]  d_req_addr;
  logic [127:0] d_req_wdata;
  logic [15:0]  d_req_wmask;
  logic         d_resp_valid;
  logic [127:0] d_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rnw;
  logic [27:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic [15:0]  mem_req_wmask;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         busy, err_spurious;
  logic [1:0]   dbg_state;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_rnw(d_req_rnw),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err_spurious(err_spurious), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [127:0]  exp_q[$];
  logic [127:0]  mem_m[logic [27:0]];
  bit            i_pend, d_pend, d_rnw_p;
  logic [27:0]   i_addr_p, d_addr_p;
  logic [127:0]  d_wdata_p;
  logic [15:0]   d_wmask_p;
  bit            last_d;       // last granted requester was dcache
  bit            err_exp;
  logic [127:0]  exp_i_data, exp_d_data;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mem_rd(input logic [27:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {4{4'hA, a}};
  endfunction

  function automatic void mem_wr(input logic [27:0] a, input logic [127:0] wd, input logic [15:0] wm);
    logic [127:0] line;
    line = mem_rd(a);
    for (int b = 0; b < 16; b++)
      if (wm[b]) line[8*b +: 8] = wd[8*b +: 8];
    mem_m[a] = line;
  endfunction

  // Arbitration rule: a lone requester wins; with both, dcache (fixed) or the one not last served.
  function automatic bit pick_d();
    if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return d_pend;
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    i_req_valid = i_pend;
    i_req_addr  = i_addr_p;
    d_req_valid = d_pend;
    d_req_rnw   = d_rnw_p;
    d_req_addr  = d_addr_p;
    d_req_wdata = d_wdata_p;
    d_req_wmask = d_wmask_p;
  endtask

  task automatic add_i(input logic [27:0] a);
    i_pend = 1'b1; i_addr_p = a;
  endtask

  task automatic add_d(input bit rnw, input logic [27:0] a, input logic [127:0] wd, input logic [15:0] wm);
    d_pend = 1'b1; d_rnw_p = rnw; d_addr_p = a; d_wdata_p = wd; d_wmask_p = wm;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_ctrl"}, {i_req_ready, i_resp_valid, d_req_ready, d_resp_valid,
                              mem_req_valid, mem_req_rnw, busy, err_spurious, dbg_state}, '0);
    check_eq({pfx, "_idata"}, i_resp_data, '0);
    check_eq({pfx, "_ddata"}, d_resp_data, '0);
    check_eq({pfx, "_maddr"}, mem_req_addr, '0);
    check_eq({pfx, "_mwdata"}, mem_req_wdata, '0);
    check_eq({pfx, "_mwmask"}, mem_req_wmask, '0);
  endtask

  // One full transaction from the IDLE grant cycle through the cycle after RESP.
  task automatic run_txn(input int rdy_dly, input int rsp_dly, input bit withdraw);
    bit           win_d, rnw;
    logic [27:0]  addr;
    logic [127:0] wd, exp;
    logic [15:0]  wm;
    if (!i_pend && !d_pend) return;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    drive_req();
    #1;
    win_d = pick_d();
    check_eq("i_ready", i_req_ready, !win_d);
    check_eq("d_ready", d_req_ready, win_d);
    check_eq("busy_idle", busy, 1'b0);
    if (win_d) begin
      rnw = d_rnw_p; addr = d_addr_p; wd = d_wdata_p; wm = d_wmask_p; d_pend = 1'b0;
    end else begin
      rnw = 1'b1; addr = i_addr_p; wd = '0; wm = '0; i_pend = 1'b0;
    end
    last_d = win_d;
    exp_q.push_back(rnw ? mem_rd(addr) : 128'd0);
    for (int k = 0; k <= rdy_dly; k++) begin
      cyc();
      if (k == 0 && withdraw) begin i_pend = 1'b0; d_pend = 1'b0; end
      drive_req();
      mem_req_ready = (k == rdy_dly);
      #1;
      check_eq("mreq_valid", mem_req_valid, 1'b1);
      check_eq("mreq_rnw", mem_req_rnw, rnw);
      check_eq("mreq_addr", mem_req_addr, addr);
      check_eq("mreq_wdata", mem_req_wdata, wd);
      check_eq("mreq_wmask", mem_req_wmask, wm);
      check_eq("ready_busy", {i_req_ready, d_req_ready}, 2'b00);
    end
    if (rnw) begin
      for (int k = 0; k <= rsp_dly; k++) begin
        cyc();
        mem_req_ready  = 1'b0;
        mem_resp_valid = (k == rsp_dly);
        mem_resp_data  = (k == rsp_dly) ? mem_rd(addr) : rnd128();
        #1;
        check_eq("no_early_resp", {i_resp_valid, d_resp_valid, mem_req_valid}, 3'b000);
        check_eq("busy_wait", busy, 1'b1);
      end
    end else begin
      mem_wr(addr, wd, wm);
    end
    cyc();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #1;
    exp = exp_q.pop_front();
    if (win_d) exp_d_data = exp;
    else       exp_i_data = exp;
    check_eq("resp_valid", {i_resp_valid, d_resp_valid}, win_d ? 2'b01 : 2'b10);
    check_eq("i_resp_data", i_resp_data, exp_i_data);
    check_eq("d_resp_data", d_resp_data, exp_d_data);
    cyc();
    check_eq("resp_done", {i_resp_valid, d_resp_valid, busy}, 3'b000);
    check_eq("err_flag", err_spurious, err_exp);
  endtask

  task automatic drain();
    while (i_pend || d_pend) run_txn(0, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    i_pend = 0; d_pend = 0; d_rnw_p = 1; i_addr_p = '0; d_addr_p = '0;
    d_wdata_p = '0; d_wmask_p = '0; last_d = 0; err_exp = 0;
    exp_i_data = '0; exp_d_data = '0;
    mem_req_ready = 0; mem_resp_data = '0;

    // Reset with requests and a memory response active: everything must stay 0.
    reset_n = 1'b0;
    i_req_valid = 1'b1; d_req_valid = 1'b1; mem_resp_valid = 1'b1;
    i_req_addr = 28'h1; d_req_addr = 28'h2; d_req_rnw = 1'b1;
    d_req_wdata = '1; d_req_wmask = '1;
    repeat (3) cyc();
    check_all_zero("reset");
    i_req_valid = 1'b0; d_req_valid = 1'b0; mem_resp_valid = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    // Simultaneous reads: dcache first, icache (0x0000010) next.
    add_i(28'h0000010);
    add_d(1'b1, 28'h0000040, '0, '0);
    run_txn(0, 0, 1'b0);
    run_txn(1, 2, 1'b0);

    // Four back-to-back contended grants.
    for (int t = 0; t < 4; t++) begin
      if (!i_pend) add_i(28'($urandom_range(0, 15)));
      if (!d_pend) add_d(1'b1, 28'($urandom_range(0, 15)), rnd128(), 16'($urandom));
      run_txn(0, 1, 1'b0);
    end
    drain();

    // Write with memory ready held off for 5 cycles, then read it back.
    add_d(1'b0, 28'h0000020, 128'h11223344_55667788_99AABBCC_DDEEFF00, 16'h000F);
    run_txn(5, 0, 1'b0);
    add_d(1'b1, 28'h0000020, '0, '0);
    run_txn(0, 0, 1'b0);

    // Minimum read latency with a known line.
    mem_m[28'h0000030] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    add_i(28'h0000030);
    run_txn(0, 0, 1'b0);

    // Randomized mix of reads, masked writes, delays and loser withdrawals.
    for (int t = 0; t < 150; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) add_i(28'($urandom_range(0, 15)));
      if (!d_pend && $urandom_range(0, 1) == 1)
        add_d(1'($urandom_range(0, 1)), 28'($urandom_range(0, 15)), rnd128(), 16'($urandom));
      if (!i_pend && !d_pend)
        add_d(1'b0, 28'($urandom_range(0, 15)), rnd128(), 16'($urandom));
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    drain();

    // Spurious memory response in IDLE: sticky error, no response pulse.
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = rnd128();
    #1;
    check_eq("spur_pre", err_spurious, 1'b0);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    err_exp = 1'b1;
    check_eq("spur_set", err_spurious, 1'b1);
    check_eq("spur_noresp", {i_resp_valid, d_resp_valid, busy}, 3'b000);
    check_eq("spur_data", i_resp_data, exp_i_data);
    repeat (3) cyc();
    check_eq("spur_sticky", err_spurious, 1'b1);
    add_d(1'b1, 28'h5, '0, '0);
    run_txn(0, 0, 1'b0);

    // Reset while waiting for read data, then a late response after release.
    add_i(28'h0000050);
    drive_req();
    #1;
    check_eq("mr_grant", i_req_ready, 1'b1);
    i_pend = 1'b0;
    cyc();
    drive_req();
    mem_req_ready = 1'b1;
    #1;
    check_eq("mr_issue", mem_req_valid, 1'b1);
    cyc();
    mem_req_ready = 1'b0;
    #1;
    check_eq("mr_wait_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mr_reset");
    err_exp = 1'b0; exp_i_data = '0; exp_d_data = '0; last_d = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    #1;
    check_eq("mr_late_err0", err_spurious, 1'b0);
    cyc();
    mem_resp_valid = 1'b0;
    #1;
    check_eq("mr_noresp", {i_resp_valid, d_resp_valid, busy}, 3'b000);
    check_eq("mr_idata", i_resp_data, '0);
    check_eq("mr_err", err_spurious, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
